// File: rtl/uart_pkg.sv
// Shared constants and types for the buffered UART transmitter.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and registered full/empty/count.
// Writes into a full FIFO and reads from an empty one are ignored here;
// reporting of dropped writes belongs to the instantiating block.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             r_full;
  logic             r_empty;
  logic             w_push_ok;
  logic             w_pop_ok;

  // Gating uses the registered flags, so a pop in the same cycle never frees a slot for a write.
  assign w_push_ok    = push & ~r_full;
  assign w_pop_ok     = pop & ~r_empty;
  assign w_count_next = r_count + CW'(w_push_ok) - CW'(w_pop_ok);

  // Storage array; left unreset so it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and flags, all updated from the next occupancy value.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == CW'(DEPTH));
      r_empty <= (w_count_next == '0);
    end
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign full     = r_full;
  assign empty    = r_empty;
  assign count    = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO in front of a start/data/parity/stop framer.
//
// state  | meaning
// IDLE   | line high, waiting for a FIFO entry
// START  | start bit (low) for one bit period
// DATA   | payload bits, LSB first
// PARITY | parity bit latched at load time
// STOP   | stop bit(s) high; reloads directly from FIFO on last cycle
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);

  import uart_pkg::*;

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  uart_tx_state_t        r_state;
  uart_tx_state_t        w_state_next;
  logic [BAUD_W-1:0]     r_baud;
  logic [BAUD_W-1:0]     w_baud_next;
  logic [BIT_W-1:0]      r_bit;
  logic [BIT_W-1:0]      w_bit_next;
  logic [DATA_BITS-1:0]  r_shift;
  logic [DATA_BITS-1:0]  w_shift_next;
  logic                  r_par;
  logic                  w_par_next;
  logic                  r_tx;
  logic                  w_tx_next;
  logic                  r_overflow;
  logic                  w_load;
  logic                  w_pop;
  logic                  w_baud_end;
  logic                  w_par_calc;
  logic [DATA_BITS-1:0]  w_head;
  logic                  w_full;
  logic                  w_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (count)
  );

  assign w_baud_end = (r_baud == BAUD_LAST);
  assign w_par_calc = (PARITY == PAR_ODD) ? ~(^w_head) : (^w_head);

  // Dropped-write flag: a write seen while the FIFO was already full.
  always_ff @(posedge clock) begin
    if (reset) r_overflow <= 1'b0;
    else       r_overflow <= wr_en & w_full;
  end

  // Framer next-state, counters, and the line value for the next cycle.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_par_next   = r_par;
    w_load       = 1'b0;
    w_pop        = 1'b0;
    w_tx_next    = 1'b1;

    case (r_state)
      IDLE: begin
        w_load = ~w_empty;
      end
      START: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = DATA;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      DATA: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};
          if (r_bit == DATA_LAST) begin
            w_bit_next   = '0;
            w_state_next = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
          end else begin
            w_bit_next = r_bit + BIT_W'(1);
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      uart_pkg::PARITY: begin
        if (w_baud_end) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = STOP;
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      STOP: begin
        if (w_baud_end) begin
          w_baud_next = '0;
          if (r_bit == STOP_LAST) begin
            w_bit_next = '0;
            if (!w_empty) w_load = 1'b1;
            else          w_state_next = IDLE;
          end else begin
            w_bit_next = r_bit + BIT_W'(1);
          end
        end else begin
          w_baud_next = r_baud + BAUD_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Loading from IDLE or from the last stop cycle is identical.
    if (w_load) begin
      w_pop        = 1'b1;
      w_shift_next = w_head;
      w_par_next   = w_par_calc;
      w_baud_next  = '0;
      w_bit_next   = '0;
      w_state_next = START;
    end

    case (w_state_next)
      START:            w_tx_next = 1'b0;
      DATA:             w_tx_next = w_shift_next[0];
      uart_pkg::PARITY: w_tx_next = w_par_next;
      default:          w_tx_next = 1'b1;
    endcase
  end

  // Framer state and registered line output.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_par   <= w_par_next;
      r_tx    <= w_tx_next;
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign overflow = r_overflow;
  assign busy     = (r_state != IDLE);
  assign tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four differently configured instances share one
// stimulus stream; a frame-timeline model predicts every output each cycle.
module tb_uart_tx_fifo;

  localparam int NI   = 4;
  localparam int MAXW = 1024;

  localparam int A_DB = 8, A_DEP = 4, A_CPB = 4, A_PAR = 0, A_SB = 1;
  localparam int B_DB = 8, B_DEP = 8, B_CPB = 3, B_PAR = 0, B_SB = 2;
  localparam int C_DB = 8, C_DEP = 2, C_CPB = 2, C_PAR = 2, C_SB = 1;
  localparam int D_DB = 5, D_DEP = 4, D_CPB = 5, D_PAR = 1, D_SB = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;

  logic full_o  [NI];
  logic empty_o [NI];
  logic ovf_o   [NI];
  logic busy_o  [NI];
  logic tx_o    [NI];
  logic [2:0] cnt_a;
  logic [3:0] cnt_b;
  logic [1:0] cnt_c;
  logic [2:0] cnt_d;

  always #5 clock = ~clock;

  uart_tx_fifo #(.DATA_BITS(A_DB), .FIFO_DEPTH(A_DEP), .CLKS_PER_BIT(A_CPB),
                 .PARITY(A_PAR), .STOP_BITS(A_SB)) u_dut_a (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_o[0]), .empty(empty_o[0]), .count(cnt_a), .overflow(ovf_o[0]),
    .busy(busy_o[0]), .tx(tx_o[0]));

  uart_tx_fifo #(.DATA_BITS(B_DB), .FIFO_DEPTH(B_DEP), .CLKS_PER_BIT(B_CPB),
                 .PARITY(B_PAR), .STOP_BITS(B_SB)) u_dut_b (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_o[1]), .empty(empty_o[1]), .count(cnt_b), .overflow(ovf_o[1]),
    .busy(busy_o[1]), .tx(tx_o[1]));

  uart_tx_fifo #(.DATA_BITS(C_DB), .FIFO_DEPTH(C_DEP), .CLKS_PER_BIT(C_CPB),
                 .PARITY(C_PAR), .STOP_BITS(C_SB)) u_dut_c (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full_o[2]), .empty(empty_o[2]), .count(cnt_c), .overflow(ovf_o[2]),
    .busy(busy_o[2]), .tx(tx_o[2]));

  uart_tx_fifo #(.DATA_BITS(D_DB), .FIFO_DEPTH(D_DEP), .CLKS_PER_BIT(D_CPB),
                 .PARITY(D_PAR), .STOP_BITS(D_SB)) u_dut_d (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_data(wr_data[4:0]),
    .full(full_o[3]), .empty(empty_o[3]), .count(cnt_d), .overflow(ovf_o[3]),
    .busy(busy_o[3]), .tx(tx_o[3]));

  int cfg_db [NI];
  int cfg_dep[NI];
  int cfg_cpb[NI];
  int cfg_par[NI];
  int cfg_sb [NI];

  // Per instance: accept cycle, frame start cycle and payload of each accepted word.
  int m_a [NI][MAXW];
  int m_s [NI][MAXW];
  int m_d [NI][MAXW];
  int m_n [NI];
  int m_last_end [NI];
  bit m_ovf [NI];

  int t;
  int n_tot;
  int n_bad;
  bit chk_en;
  int ovf_seen_a;

  task automatic chk(input string tag, input int got, input int exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int frame_len(input int i);
    return (1 + cfg_db[i] + ((cfg_par[i] != 0) ? 1 : 0) + cfg_sb[i]) * cfg_cpb[i];
  endfunction

  // Occupancy seen in cycle tc: writes visible the cycle after acceptance,
  // each word leaves the FIFO in the cycle its frame starts.
  function automatic int occ(input int i, input int tc);
    int c = 0;
    for (int k = 0; k < m_n[i]; k++) begin
      if (m_a[i][k] + 1 <= tc) c++;
      if (m_s[i][k] <= tc) c--;
    end
    return c;
  endfunction

  function automatic int active_frame(input int i, input int tc);
    for (int k = 0; k < m_n[i]; k++) begin
      if (tc >= m_s[i][k] && tc < m_s[i][k] + frame_len(i)) return k;
    end
    return -1;
  endfunction

  // Line level for bit slot idx of a frame carrying w.
  function automatic int line_bit(input int i, input int w, input int idx);
    int x;
    if (idx == 0) return 0;
    if (idx <= cfg_db[i]) return (w >> (idx - 1)) & 1;
    if (cfg_par[i] != 0 && idx == cfg_db[i] + 1) begin
      x = $countones(w) & 1;
      return (cfg_par[i] == 2) ? x : 1 - x;
    end
    return 1;
  endfunction

  function automatic int obs_cnt(input int i);
    case (i)
      0:       return int'(cnt_a);
      1:       return int'(cnt_b);
      2:       return int'(cnt_c);
      default: return int'(cnt_d);
    endcase
  endfunction

  function automatic bit model_idle();
    for (int i = 0; i < NI; i++) begin
      if (t < m_last_end[i] || occ(i, t) != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_all();
    int c, k, exp_tx;
    for (int i = 0; i < NI; i++) begin
      c = occ(i, t);
      k = active_frame(i, t);
      exp_tx = (k >= 0) ? line_bit(i, m_d[i][k], (t - m_s[i][k]) / cfg_cpb[i]) : 1;
      chk($sformatf("u%0d.count@%0d", i, t), obs_cnt(i), c);
      chk($sformatf("u%0d.full@%0d", i, t), int'(full_o[i]), (c == cfg_dep[i]) ? 1 : 0);
      chk($sformatf("u%0d.empty@%0d", i, t), int'(empty_o[i]), (c == 0) ? 1 : 0);
      chk($sformatf("u%0d.overflow@%0d", i, t), int'(ovf_o[i]), int'(m_ovf[i]));
      chk($sformatf("u%0d.busy@%0d", i, t), int'(busy_o[i]), (k >= 0) ? 1 : 0);
      chk($sformatf("u%0d.tx@%0d", i, t), int'(tx_o[i]), exp_tx);
    end
    if (ovf_o[0] === 1'b1) ovf_seen_a++;
  endtask

  task automatic model_update(input bit we, input int data, input bit rst);
    int c, s;
    for (int i = 0; i < NI; i++) begin
      c = occ(i, t);
      if (rst) begin
        m_n[i] = 0;
        m_last_end[i] = 0;
        m_ovf[i] = 1'b0;
      end else begin
        m_ovf[i] = we && (c == cfg_dep[i]);
        if (we && c < cfg_dep[i] && m_n[i] < MAXW) begin
          s = (t + 2 > m_last_end[i]) ? t + 2 : m_last_end[i];
          m_a[i][m_n[i]] = t;
          m_s[i][m_n[i]] = s;
          m_d[i][m_n[i]] = data & ((1 << cfg_db[i]) - 1);
          m_last_end[i] = s + frame_len(i);
          m_n[i]++;
        end
      end
    end
  endtask

  // One clock cycle: inputs for cycle t, check outputs of cycle t, advance model.
  task automatic step(input bit we, input int data, input bit rst);
    wr_en   = we;
    wr_data = 8'(data);
    reset   = rst;
    if (chk_en) check_all();
    model_update(we, data, rst);
    @(negedge clock);
    t++;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while (!model_idle() && n < maxc) begin
      step(1'b0, 0, 1'b0);
      n++;
    end
    if (!model_idle()) chk("idle_timeout", 0, 1);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
  endtask

  initial begin
    int prob;
    bit we, rst;
    cfg_db  = '{A_DB,  B_DB,  C_DB,  D_DB};
    cfg_dep = '{A_DEP, B_DEP, C_DEP, D_DEP};
    cfg_cpb = '{A_CPB, B_CPB, C_CPB, D_CPB};
    cfg_par = '{A_PAR, B_PAR, C_PAR, D_PAR};
    cfg_sb  = '{A_SB,  B_SB,  C_SB,  D_SB};
    for (int i = 0; i < NI; i++) begin
      m_n[i] = 0;
      m_last_end[i] = 0;
      m_ovf[i] = 1'b0;
    end
    t = 0;
    n_tot = 0;
    n_bad = 0;
    ovf_seen_a = 0;
    chk_en = 1'b0;
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = '0;

    @(negedge clock);
    step(1'b0, 0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);

    // single frame
    step(1'b1, 8'h55, 1'b0);
    wait_idle(400);

    // parity pattern
    step(1'b1, 8'h07, 1'b0);
    wait_idle(400);

    // six back-to-back writes into an idle line
    ovf_seen_a = 0;
    for (int j = 0; j < 6; j++) step(1'b1, 8'h31 + j * 8'h11, 1'b0);
    wait_idle(1500);
    chk("ovf_pulses_a", ovf_seen_a, 1);

    // contiguous frames
    step(1'b1, 8'hA0, 1'b0);
    step(1'b1, 8'h0F, 1'b0);
    wait_idle(600);

    // reset during data bit 3 of instance A's frame, two entries queued
    for (int j = 0; j < 3; j++) step(1'b1, int'($urandom_range(0, 255)), 1'b0);
    for (int j = 0; j < 16; j++) step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
    for (int j = 0; j < 100; j++) step(1'b0, 0, 1'b0);

    // randomized traffic with varying burstiness and occasional resets
    prob = 10;
    for (int j = 0; j < 3000; j++) begin
      if (j % 200 == 0) begin
        case ($urandom_range(0, 3))
          0:       prob = 2;
          1:       prob = 10;
          2:       prob = 40;
          default: prob = 90;
        endcase
      end
      rst = ($urandom_range(0, 499) == 0);
      we  = !rst && ($urandom_range(0, 99) < prob);
      step(we, int'($urandom_range(0, 255)), rst);
    end
    wait_idle(4000);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
